mccu_quota_ctrl: RTL and testbench

- Per-core budget controller that writes the quota interface of the Maximum-Contention Control Unit and consumes its quota interruptions.
- Periodically reloads each core's contention budget.
- Sits between the software-set register bank and the MCCU:
  - latches each quota exhaustion;
  - asserts a per-core stall request to the core's fetch throttle;
  - counts overruns for software.

---
 rtl/mccu_pkg.sv | 16 +
 rtl/mccu_period_timer.sv | 41 ++++
 rtl/mccu_quota_ctrl.sv | 82 ++++++++
 tb/tb_mccu_quota_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mccu_pkg.sv
// Shared types and default widths for the MCCU quota controller.
`default_nettype none

package mccu_pkg;

  localparam int DATA_WIDTH_D = 32;
  localparam int OVR_WIDTH_D  = 16;

  typedef enum logic [0:0] {
    RUN       = 1'b0,
    EXHAUSTED = 1'b1
  } core_state_e;

endpackage

`default_nettype wire

// File: rtl/mccu_period_timer.sv
// Enable-edge detection, replenish-period counter and reload/tick generation.
`default_nettype none

module mccu_period_timer #(
  parameter int PERIOD_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  output logic                    reload_o,
  output logic                    period_tick_o
);

  logic                    enable_q;
  logic [PERIOD_WIDTH-1:0] count;
  logic                    period_end;

  assign period_end = (period_i != '0) && (count == (period_i - PERIOD_WIDTH'(1)));
  assign reload_o   = enable_i && (!enable_q || period_end);

  // A period shrunk below the running count restarts from 0 without a reload.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enable_q      <= 1'b0;
      count         <= '0;
      period_tick_o <= 1'b0;
    end else begin
      enable_q      <= enable_i;
      period_tick_o <= reload_o;
      if (!enable_i || reload_o || (period_i == '0) || (count >= period_i)) begin
        count <= '0;
      end else begin
        count <= count + PERIOD_WIDTH'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mccu_quota_ctrl.sv
// Per-core budget controller: drives MCCU quota_i, latches exhaustions into stalls,
// counts overruns and raises a shared interrupt.
`default_nettype none

module mccu_quota_ctrl
  import mccu_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_D,
  parameter int N_CORES      = 4,
  parameter int PERIOD_WIDTH = 32,
  parameter int OVR_WIDTH    = OVR_WIDTH_D
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               enable_i,
  input  logic [PERIOD_WIDTH-1:0]            period_i,
  input  logic [N_CORES-1:0][DATA_WIDTH-1:0] budget_i,
  input  logic [N_CORES-1:0][DATA_WIDTH-1:0] quota_fb_i,
  input  logic [N_CORES-1:0]                 interruption_quota_i,
  output logic [N_CORES-1:0][DATA_WIDTH-1:0] quota_o,
  output logic [N_CORES-1:0]                 stall_o,
  output logic [N_CORES-1:0][OVR_WIDTH-1:0]  overrun_cnt_o,
  output logic                               period_tick_o,
  output logic                               irq_o
);

  logic               reload;
  logic [N_CORES-1:0] new_exhaust;

  mccu_period_timer #(
    .PERIOD_WIDTH (PERIOD_WIDTH)
  ) u_timer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .period_i      (period_i),
    .reload_o      (reload),
    .period_tick_o (period_tick_o)
  );

  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    core_state_e          state;
    logic                 stall_q;
    logic [OVR_WIDTH-1:0] ovr_q;

    // Echoing the feedback keeps the MCCU from reloading outside reload cycles.
    assign quota_o[c]       = reload ? budget_i[c] : quota_fb_i[c];
    assign new_exhaust[c]   = enable_i && (state == RUN) && interruption_quota_i[c] && !reload;
    assign stall_o[c]       = stall_q;
    assign overrun_cnt_o[c] = ovr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state   <= RUN;
        stall_q <= 1'b0;
        ovr_q   <= '0;
      end else begin
        if (!enable_i || reload) begin
          state   <= RUN;
          stall_q <= 1'b0;
        end else if (new_exhaust[c]) begin
          state   <= EXHAUSTED;
          stall_q <= 1'b1;
        end
        if (new_exhaust[c] && (ovr_q != '1)) begin
          ovr_q <= ovr_q + OVR_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |new_exhaust;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mccu_quota_ctrl.sv
// Scoreboard bench for mccu_quota_ctrl: a cycle model queues expected outputs per cycle.
`default_nettype none

module tb_mccu_quota_ctrl;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int PW = 32;
  localparam int OW = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   enable;
  logic [PW-1:0]          period;
  logic [NC-1:0][DW-1:0]  budget;
  logic [NC-1:0][DW-1:0]  fb;
  logic [NC-1:0]          intr;
  logic [NC-1:0][DW-1:0]  quota;
  logic [NC-1:0]          stall;
  logic [NC-1:0][OW-1:0]  ovr;
  logic                   tick;
  logic                   irq;

  mccu_quota_ctrl #(
    .DATA_WIDTH   (DW),
    .N_CORES      (NC),
    .PERIOD_WIDTH (PW),
    .OVR_WIDTH    (OW)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .enable_i             (enable),
    .period_i             (period),
    .budget_i             (budget),
    .quota_fb_i           (fb),
    .interruption_quota_i (intr),
    .quota_o              (quota),
    .stall_o              (stall),
    .overrun_cnt_o        (ovr),
    .period_tick_o        (tick),
    .irq_o                (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NC-1:0]         stall;
    logic [NC-1:0][OW-1:0] ovr;
    logic                  tick;
    logic                  irq;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  bit          m_en_q;
  int unsigned m_cnt;
  bit [NC-1:0] m_exh;
  int          m_ovr[NC];
  bit          m_tick;
  bit          m_irq;

  function automatic bit m_rel();
    return enable && (!m_en_q || (period != 0 && m_cnt == period - 1));
  endfunction

  function automatic logic [NC-1:0][DW-1:0] m_quota();
    logic [NC-1:0][DW-1:0] q;
    for (int c = 0; c < NC; c++) q[c] = m_rel() ? budget[c] : fb[c];
    return q;
  endfunction

  task automatic m_reset();
    m_en_q = 0; m_cnt = 0; m_exh = '0; m_tick = 0; m_irq = 0;
    for (int c = 0; c < NC; c++) m_ovr[c] = 0;
    sbq.delete();
  endtask

  // Advance the model by one clock, queue its outputs, then let the DUT clock.
  task automatic step();
    exp_t e;
    bit   rel;
    bit   any;
    rel = m_rel();
    any = 0;
    for (int c = 0; c < NC; c++) begin
      if (enable && !m_exh[c] && intr[c] && !rel) begin
        any = 1;
        if (m_ovr[c] < (1 << OW) - 1) m_ovr[c]++;
        m_exh[c] = 1;
      end
      if (!enable || rel) m_exh[c] = 0;
    end
    if (!enable || rel || period == 0 || m_cnt >= period) m_cnt = 0;
    else m_cnt++;
    m_tick = rel;
    m_irq  = any;
    m_en_q = enable;
    e.stall = m_exh;
    for (int c = 0; c < NC; c++) e.ovr[c] = OW'(m_ovr[c]);
    e.tick = m_tick;
    e.irq  = m_irq;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      step();
      e = sbq.pop_front();
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1; enable = 0; period = '0; intr = '0;
    for (int c = 0; c < NC; c++) begin budget[c] = DW'(200 + c); fb[c] = DW'(7); end
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    checks++; if (quota !== {NC{32'd7}}) begin errors++; $display("FAIL reset_quota got %h exp all 7", quota); end
    checks++; if (stall !== '0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (ovr !== '0) begin errors++; $display("FAIL reset_ovr got %h exp 0", ovr); end
    checks++; if (tick !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL reset_pulses tick %b irq %b exp 0 0", tick, irq); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (quota !== m_quota()) begin errors++; $display("FAIL idle_quota cyc %0d got %h exp %h", i, quota, m_quota()); end
      step(); e = sbq.pop_front();
      checks++; if (stall !== e.stall || tick !== e.tick || irq !== e.irq) begin errors++; $display("FAIL idle_out cyc %0d got %b/%b/%b exp %b/%b/%b", i, stall, tick, irq, e.stall, e.tick, e.irq); end
    end
  endtask

  task automatic test_enable_edge();
    exp_t e;
    int   ticks = 0;
    budget[0] = DW'(100);
    fb = '0;
    enable = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (quota[0] !== ((i == 0) ? DW'(100) : DW'(0))) begin errors++; $display("FAIL edge_quota0 cyc %0d got %0d exp %0d", i, quota[0], (i == 0) ? 100 : 0); end
      checks++; if (quota !== m_quota()) begin errors++; $display("FAIL edge_quota cyc %0d got %h exp %h", i, quota, m_quota()); end
      step(); e = sbq.pop_front();
      if (tick) ticks++;
      checks++; if (tick !== e.tick) begin errors++; $display("FAIL edge_tick cyc %0d got %b exp %b", i, tick, e.tick); end
    end
    checks++; if (ticks != 1) begin errors++; $display("FAIL edge_tick_count got %0d exp 1", ticks); end
  endtask

  task automatic test_periodic();
    exp_t e;
    int   tq[$];
    enable = 0; settle(1);
    period = PW'(10);
    for (int c = 0; c < NC; c++) fb[c] = DW'(50 + c);
    enable = 1;
    for (int i = 0; i < 25; i++) begin
      #1;
      checks++; if (quota !== m_quota()) begin errors++; $display("FAIL per_quota cyc %0d got %h exp %h", i, quota, m_quota()); end
      step(); e = sbq.pop_front();
      if (tick) tq.push_back(i);
      checks++; if (tick !== e.tick) begin errors++; $display("FAIL per_tick cyc %0d got %b exp %b", i, tick, e.tick); end
    end
    checks++;
    if (tq.size() != 3 || tq[0] != 0 || tq[1] != 10 || tq[2] != 20) begin
      errors++; $display("FAIL per_tick_cycles got %0d ticks exp 3 at 0,10,20", tq.size());
    end
  endtask

  task automatic test_exhaustion();
    exp_t e;
    int   irqs = 0;
    enable = 0; settle(1);
    period = PW'(10);
    enable = 1;
    for (int i = 0; i < 12; i++) begin
      intr = '0;
      intr[1] = (i >= 3 && i <= 5);
      #1;
      checks++; if (quota !== m_quota()) begin errors++; $display("FAIL exh_quota cyc %0d got %h exp %h", i, quota, m_quota()); end
      step(); e = sbq.pop_front();
      if (irq) irqs++;
      checks++; if (stall !== e.stall || ovr !== e.ovr || irq !== e.irq) begin errors++; $display("FAIL exh_out cyc %0d got %b/%h/%b exp %b/%h/%b", i, stall, ovr, irq, e.stall, e.ovr, e.irq); end
      if (i == 3 || i == 9) begin checks++; if (stall[1] !== 1'b1) begin errors++; $display("FAIL exh_stall_on cyc %0d got %b exp 1", i, stall[1]); end end
      if (i == 10) begin checks++; if (stall[1] !== 1'b0) begin errors++; $display("FAIL exh_stall_off got %b exp 0", stall[1]); end end
    end
    intr = '0;
    checks++; if (ovr[1] !== OW'(1)) begin errors++; $display("FAIL exh_count got %0d exp 1", ovr[1]); end
    checks++; if (irqs != 1) begin errors++; $display("FAIL exh_irq_pulses got %0d exp 1", irqs); end
  endtask

  task automatic test_collision();
    exp_t e;
    enable = 0; settle(1);
    enable = 1;
    for (int i = 0; i < 4; i++) begin
      intr = '0;
      intr[2] = (i <= 1);
      if (i == 2) begin intr[0] = 1; intr[3] = 1; end
      #1;
      checks++; if (quota !== m_quota()) begin errors++; $display("FAIL col_quota cyc %0d got %h exp %h", i, quota, m_quota()); end
      step(); e = sbq.pop_front();
      checks++; if (stall !== e.stall || ovr !== e.ovr || irq !== e.irq) begin errors++; $display("FAIL col_out cyc %0d got %b/%h/%b exp %b/%h/%b", i, stall, ovr, irq, e.stall, e.ovr, e.irq); end
      if (i == 0) begin checks++; if (stall[2] !== 1'b0 || ovr[2] !== OW'(0) || irq !== 1'b0) begin errors++; $display("FAIL col_reload_wins got %b/%0d/%b exp 0/0/0", stall[2], ovr[2], irq); end end
      if (i == 1) begin checks++; if (stall[2] !== 1'b1 || ovr[2] !== OW'(1)) begin errors++; $display("FAIL col_next got %b/%0d exp 1/1", stall[2], ovr[2]); end end
      if (i == 3) begin checks++; if (irq !== 1'b0) begin errors++; $display("FAIL col_irq_single got %b exp 0", irq); end end
    end
    intr = '0;
  endtask

  task automatic test_saturation_disable();
    exp_t e;
    int   tq[$];
    enable = 0; settle(1);
    period = PW'(4);
    enable = 1;
    for (int i = 0; i < 20; i++) begin
      intr = '0;
      intr[3] = (i % 4 == 2);
      #1;
      checks++; if (quota !== m_quota()) begin errors++; $display("FAIL sat_quota cyc %0d got %h exp %h", i, quota, m_quota()); end
      step(); e = sbq.pop_front();
      checks++; if (stall !== e.stall || ovr !== e.ovr || irq !== e.irq) begin errors++; $display("FAIL sat_out cyc %0d got %b/%h/%b exp %b/%h/%b", i, stall, ovr, irq, e.stall, e.ovr, e.irq); end
    end
    intr = '0;
    checks++; if (ovr[3] !== 2'd3 || stall[3] !== 1'b1) begin errors++; $display("FAIL sat_count got %0d stall %b exp 3 stall 1", ovr[3], stall[3]); end
    enable = 0;
    step(); e = sbq.pop_front();
    checks++; if (stall !== '0 || ovr[3] !== 2'd3) begin errors++; $display("FAIL dis_state got stall %b ovr3 %0d exp 0 and 3", stall, ovr[3]); end
    enable = 1;
    for (int i = 0; i < 7; i++) begin
      intr = '0;
      intr[0] = (i == 5);
      #1;
      checks++; if (quota !== m_quota()) begin errors++; $display("FAIL ren_quota cyc %0d got %h exp %h", i, quota, m_quota()); end
      step(); e = sbq.pop_front();
      if (tick) tq.push_back(i);
      checks++; if (stall !== e.stall || tick !== e.tick) begin errors++; $display("FAIL ren_out cyc %0d got %b/%b exp %b/%b", i, stall, tick, e.stall, e.tick); end
    end
    intr = '0;
    checks++; if (tq.size() != 2 || tq[0] != 0 || tq[1] != 4) begin errors++; $display("FAIL ren_tick_cycles got %0d ticks exp 2 at 0,4", tq.size()); end
    checks++; if (stall[0] !== 1'b1) begin errors++; $display("FAIL pre_rst_stall got %b exp 1", stall[0]); end
    #2 rst = 1;
    #1;
    checks++; if (stall !== '0 || ovr !== '0) begin errors++; $display("FAIL async_rst got stall %b ovr %h exp 0 0", stall, ovr); end
    checks++; if (tick !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL async_rst_pulses tick %b irq %b exp 0 0", tick, irq); end
    m_reset();
    @(posedge clk);
    #1 rst = 0; enable = 0;
  endtask

  initial begin
    test_reset();
    test_enable_edge();
    test_periodic();
    test_exhaustion();
    test_collision();
    test_saturation_disable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
